if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised IF→ID pipeline boundary register with a valid/ready handshake.
- Adds an optional 2-entry skid buffer, synchronous flush with NOP-bubble insertion, and a saturating bubble counter.
- Sits between fetch (PC + instruction source) and decode.
- Decouples fetch from decode back-pressure without a combinational ready path, and kills wrong-path instructions on branch/jump resolution.

Parameters:
- PC_W, 32, width of program-counter field
- INS_W, 32, width of instruction field
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- NOP_INS, 32'h0000_0000, instruction value presented when out_valid=0
- RESET_PC, 0, value of out_pc after reset or flush
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill all held entries (branch/jump taken)
- in_valid  in  1  fetch presents pc/ins
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  fetched PC
- in_ins  in  INS_W  fetched instruction
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode accepts (0 = stall)
- out_pc  out  PC_W  PC to decode
- out_ins  out  INS_W  instruction to decode; NOP_INS when out_valid=0
- occupancy  out  2  entries held (0..2)
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating

Behaviour:
- Handshake rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or rst.
- Reset, synchronous, has priority over flush. Values after the reset edge:
  - out_valid=0, out_pc=RESET_PC, out_ins=NOP_INS
  - occupancy=0, bubble_cnt=0
  - in_ready=1
- Latency: an entry accepted into an empty stage appears on out_* the next cycle.
- Throughput: 1 entry per cycle when out_ready is held at 1.
- State machine, SKID_EN=1 (main register plus skid register):
  - EMPTY: input transfer → main loads → ONE.
  - ONE, input and output transfer in the same cycle: main loads new entry → ONE.
  - ONE, input transfer only: skid loads → TWO.
  - ONE, output transfer only → EMPTY.
  - TWO: in_ready=0. Output transfer → main loads skid content → ONE.
  - in_ready is registered and equals (next state != TWO). It never depends combinationally on out_ready.
- SKID_EN=0:
  - Only EMPTY and ONE exist.
  - in_ready = !out_valid | out_ready (combinational).
  - occupancy never exceeds 1.
- Flush:
  - Next state is EMPTY. Main and skid are invalidated; out_pc=RESET_PC, out_ins=NOP_INS.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as consumed by decode.
  - After a flush, in_ready=1.
- Stall (out_ready=0 with out_valid=1): out_pc and out_ins hold stable until the output transfer.
- bubble_cnt:
  - Increments each cycle out_valid=0, including the cycle after a flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst.
- Simultaneous flush and rst: rst wins, with identical result.
- Widths: no arithmetic on data fields. The counter adds 1 with a saturation compare.

Decomposition:
- Package if_id_pkg:
  - State enum {EMPTY, ONE, TWO} (2 bits).
  - Default NOP_INS constant.
  - Entry struct {pc, ins} parametrised via localparams in the module.
- One sub-module: sat_counter (CNT_W, inc, clear) for bubble_cnt, reusable by other pipeline stages.
- Data path and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → out_valid=0, out_ins=0, out_pc=0, in_ready=1, occupancy=0; bubble_cnt counts 1, 2, 3 on idle cycles.
- Streaming: in_valid=1 with PC 0x00,0x04,0x08,0x0C, out_ready=1 → out_pc follows 1 cycle later, no gaps, in_ready stays 1.
- Back-pressure (SKID_EN=1): out_ready=0 while sending PC 0x10, 0x14, 0x18 →
  - 0x10 in main, 0x14 in skid, occupancy=2.
  - in_ready=0 the cycle after 0x14 is accepted; 0x18 is held by fetch, not accepted.
  - Release out_ready → 0x10, 0x14, 0x18 delivered in order.
- Flush with input: occupancy=2 plus in_valid (PC 0x20) with flush=1 in the same cycle → next cycle out_valid=0, out_ins=NOP_INS, occupancy=0, in_ready=1; 0x20 never appears.
- SKID_EN=0: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle; out_ready=1 plus in_valid → simultaneous replace, occupancy stays 1.
- Saturation (CNT_W=4): 20 idle cycles → bubble_cnt stops at 15; rst clears it to 0.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID boundary stage.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with valid/ready handshake, optional 2-entry skid,
// flush-to-bubble and a saturating count of bubble cycles.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               INS_W    = 32,
    parameter bit               SKID_EN  = 1'b1,
    parameter logic [INS_W-1:0] NOP_INS  = INS_W'(NOP_INS_DEFAULT),
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: RESET_PC, ins: NOP_INS};

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;
    entry_t in_entry;

    assign in_entry  = '{pc: in_pc, ins: in_ins};
    assign out_valid = (state_q != EMPTY);
    // Skid mode breaks the out_ready -> in_ready path with a registered ready.
    assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign out_pc    = out_valid ? main_q.pc  : RESET_PC;
    assign out_ins   = out_valid ? main_q.ins : NOP_INS;
    assign occupancy = state_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (!out_valid),
        .count(bubble_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: three configurations driven in lockstep and
// compared against a queue-based reference model plus a directed vector table.
module tb_if_id_skid_stage;

    localparam logic [31:0] K_INS = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_ins;

    logic        o_valid [3];
    logic        o_ready [3];
    logic [31:0] o_pc    [3];
    logic [31:0] o_ins   [3];
    logic [1:0]  o_occ   [3];
    logic [15:0] bc_a, bc_b;
    logic [3:0]  bc_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // dut 0: default skid; dut 1: no skid; dut 2: narrow counter, custom bubble values
    if_id_skid_stage u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_pc(in_pc), .in_ins(in_ins), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_pc(o_pc[0]), .out_ins(o_ins[0]), .occupancy(o_occ[0]), .bubble_cnt(bc_a));

    if_id_skid_stage #(.SKID_EN(1'b0)) u_dut_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_pc(in_pc), .in_ins(in_ins), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_pc(o_pc[1]), .out_ins(o_ins[1]), .occupancy(o_occ[1]), .bubble_cnt(bc_b));

    if_id_skid_stage #(.CNT_W(4), .NOP_INS(32'h0000_0013), .RESET_PC(32'h0000_0100)) u_dut_cnt4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[2]),
        .in_pc(in_pc), .in_ins(in_ins), .out_valid(o_valid[2]), .out_ready(out_ready),
        .out_pc(o_pc[2]), .out_ins(o_ins[2]), .occupancy(o_occ[2]), .bubble_cnt(bc_c));

    // Reference model: per-dut FIFO of {pc, ins} with capacity 2 (skid) or 1.
    logic [63:0] mbuf [3][2];
    int          mcnt [3];
    int          mbc  [3];
    bit          mskid[3]  = '{1'b1, 1'b0, 1'b1};
    int          mbmax[3]  = '{65535, 65535, 15};
    logic [31:0] mnop [3]  = '{32'h0, 32'h0, 32'h13};
    logic [31:0] mrpc [3]  = '{32'h0, 32'h0, 32'h100};

    function automatic bit m_ready(int i);
        return mskid[i] ? (mcnt[i] < 2) : (mcnt[i] == 0 || out_ready);
    endfunction

    function automatic int dut_bc(int i);
        case (i)
            0:       return int'(bc_a);
            1:       return int'(bc_b);
            default: return int'(bc_c);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            bit          ev  = (mcnt[i] > 0);
            logic [31:0] epc = ev ? mbuf[i][0][63:32] : mrpc[i];
            logic [31:0] ein = ev ? mbuf[i][0][31:0]  : mnop[i];
            chk($sformatf("d%0d out_valid", i), 64'(o_valid[i]), 64'(ev));
            chk($sformatf("d%0d out_pc", i), 64'(o_pc[i]), 64'(epc));
            chk($sformatf("d%0d out_ins", i), 64'(o_ins[i]), 64'(ein));
            chk($sformatf("d%0d in_ready", i), 64'(o_ready[i]), 64'(m_ready(i)));
            chk($sformatf("d%0d occupancy", i), 64'(o_occ[i]), 64'(mcnt[i]));
            chk($sformatf("d%0d bubble_cnt", i), 64'(dut_bc(i)), 64'(mbc[i]));
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit ox = (mcnt[i] > 0) && out_ready;
            bit ix = in_valid && m_ready(i);
            if (rst) begin
                mcnt[i] = 0;
                mbc[i]  = 0;
            end else begin
                if (mcnt[i] == 0 && mbc[i] < mbmax[i]) mbc[i]++;
                if (flush) begin
                    mcnt[i] = 0;
                end else begin
                    if (ox) begin
                        mbuf[i][0] = mbuf[i][1];
                        mcnt[i]--;
                    end
                    if (ix) begin
                        mbuf[i][mcnt[i]] = {in_pc, in_ins};
                        mcnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] pc, input bit ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_ins    = pc ^ K_INS;
        out_ready = ordy;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input bit r, input bit f, input bit iv, input logic [31:0] pc, input bit ordy);
        drive(r, f, iv, pc, ordy);
        @(negedge clk);
        model_check();
        advance();
    endtask

    typedef struct {
        bit          f, iv, ordy;
        logic [31:0] pc;
        bit          ev, erdy;
        logic [31:0] epc;
        int          eocc, ebc;
    } vec_t;

    function automatic vec_t row(bit f, bit iv, logic [31:0] pc, bit ordy,
                                 bit ev, logic [31:0] epc, bit erdy, int eocc, int ebc);
        vec_t v;
        v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.ev = ev; v.epc = epc; v.erdy = erdy; v.eocc = eocc; v.ebc = ebc;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        // idle after reset, streaming, back-pressure into skid, flush from TWO, flush with input
        tbl[0]  = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0);
        tbl[1]  = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 1);
        tbl[2]  = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 2);
        tbl[3]  = row(0, 1, 32'h00, 1, 0, 32'h00, 1, 0, 3);
        tbl[4]  = row(0, 1, 32'h04, 1, 1, 32'h00, 1, 1, 4);
        tbl[5]  = row(0, 1, 32'h08, 1, 1, 32'h04, 1, 1, 4);
        tbl[6]  = row(0, 1, 32'h0C, 1, 1, 32'h08, 1, 1, 4);
        tbl[7]  = row(0, 0, 32'h00, 1, 1, 32'h0C, 1, 1, 4);
        tbl[8]  = row(0, 1, 32'h10, 0, 0, 32'h00, 1, 0, 4);
        tbl[9]  = row(0, 1, 32'h14, 0, 1, 32'h10, 1, 1, 5);
        tbl[10] = row(0, 1, 32'h18, 0, 1, 32'h10, 0, 2, 5);
        tbl[11] = row(0, 1, 32'h18, 1, 1, 32'h10, 0, 2, 5);
        tbl[12] = row(0, 1, 32'h18, 1, 1, 32'h14, 1, 1, 5);
        tbl[13] = row(0, 0, 32'h00, 1, 1, 32'h18, 1, 1, 5);
        tbl[14] = row(0, 1, 32'h30, 0, 0, 32'h00, 1, 0, 5);
        tbl[15] = row(0, 1, 32'h34, 0, 1, 32'h30, 1, 1, 6);
        tbl[16] = row(1, 1, 32'h20, 0, 1, 32'h30, 0, 2, 6);
        tbl[17] = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 6);
        tbl[18] = row(0, 1, 32'h40, 0, 0, 32'h00, 1, 0, 7);
        tbl[19] = row(1, 1, 32'h44, 1, 1, 32'h40, 1, 1, 8);
        tbl[20] = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 8);
        tbl[21] = row(0, 0, 32'h00, 1, 0, 32'h00, 1, 0, 9);

        drive(1, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            mbc[i]  = 0;
        end

        for (int n = 0; n < 22; n++) begin
            drive(0, tbl[n].f, tbl[n].iv, tbl[n].pc, tbl[n].ordy);
            @(negedge clk);
            model_check();
            chk($sformatf("tbl%0d out_valid", n), 64'(o_valid[0]), 64'(tbl[n].ev));
            chk($sformatf("tbl%0d out_pc", n), 64'(o_pc[0]), 64'(tbl[n].epc));
            chk($sformatf("tbl%0d out_ins", n), 64'(o_ins[0]),
                64'(tbl[n].ev ? (tbl[n].epc ^ K_INS) : 32'h0));
            chk($sformatf("tbl%0d in_ready", n), 64'(o_ready[0]), 64'(tbl[n].erdy));
            chk($sformatf("tbl%0d occupancy", n), 64'(o_occ[0]), 64'(tbl[n].eocc));
            chk($sformatf("tbl%0d bubble_cnt", n), 64'(bc_a), 64'(tbl[n].ebc));
            advance();
        end

        for (int n = 0; n < 400; n++) begin
            run_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
                      $urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 9) < 6);
        end

        // rst together with flush, then counter saturation on the 4-bit instance
        run_cycle(1, 1, 1, 32'h50, 1);
        for (int n = 0; n < 20; n++) run_cycle(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        chk("sat bubble_cnt", 64'(bc_c), 64'd15);
        chk("sat wide bubble_cnt", 64'(bc_a), 64'd20);
        advance();
        run_cycle(1, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        chk("rst clears bubble_cnt", 64'(bc_c), 64'd0);
        model_check();
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
